// File: rtl/gate_tester_ctrl.sv
// gate_tester_ctrl: drives all four input vectors into a 2-input gate and checks
// its output against the truth table of the selected gate function.
module gate_tester_ctrl #(
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [HOLD_W-1:0] hold,
    input  logic              gate_y,
    output logic              gate_a,
    output logic              gate_b,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [2:0]        err_cnt,
    output logic [3:0]        fail_vec
);
    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;
    state_t            r_state;
    logic [1:0]        r_vec;
    logic [2:0]        r_op;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] r_cnt;
    logic [7:0]        w_tt;
    logic              w_mis;
    logic [2:0]        w_err_nxt;
    logic [3:0]        w_fail_nxt;
    // expected gate output for the current vector, indexed by op
    assign w_tt       = {~r_vec[1], r_vec[1], ~(^r_vec), ~(|r_vec), ~(&r_vec), ^r_vec, |r_vec, &r_vec};
    assign w_mis      = gate_y != w_tt[r_op];
    assign w_err_nxt  = err_cnt + 3'(w_mis);
    assign w_fail_nxt = fail_vec | (4'(w_mis) << r_vec);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_vec    <= '0;
            r_op     <= '0;
            r_hold   <= '0;
            r_cnt    <= '0;
            gate_a   <= 1'b0;
            gate_b   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            fail_vec <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_op     <= op;
                    r_hold   <= hold;
                    r_vec    <= '0;
                    r_cnt    <= '0;
                    err_cnt  <= '0;
                    fail_vec <= '0;
                    pass     <= 1'b0;
                    busy     <= 1'b1;
                    gate_a   <= 1'b0;
                    gate_b   <= 1'b0;
                    r_state  <= APPLY;
                end
                APPLY: begin
                    if (r_cnt == r_hold) r_state <= SAMPLE;
                    else r_cnt <= r_cnt + 1'b1;
                end
                SAMPLE: begin
                    err_cnt  <= w_err_nxt;
                    fail_vec <= w_fail_nxt;
                    r_cnt    <= '0;
                    if (r_vec == 2'd3) begin
                        r_state <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= w_err_nxt == 3'd0;
                        gate_a  <= 1'b0;
                        gate_b  <= 1'b0;
                    end else begin
                        r_vec            <= r_vec + 2'd1;
                        {gate_a, gate_b} <= r_vec + 2'd1;
                        r_state          <= APPLY;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gate_tester_ctrl.sv
// tb_gate_tester_ctrl: table of gate/op runs checked through a done-time scoreboard,
// plus reset-abort, busy-disturb and back-to-back sequences.
module tb_gate_tester_ctrl;
    localparam int HW = 4;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    op = '0;
    logic [HW-1:0] hold = '0;
    logic [3:0]    kind = '0;
    logic          gate_y;
    logic          gate_a, gate_b, busy, done, pass;
    logic [2:0]    err_cnt;
    logic [3:0]    fail_vec;

    gate_tester_ctrl #(.HOLD_W(HW)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .hold(hold), .gate_y(gate_y),
        .gate_a(gate_a), .gate_b(gate_b), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .fail_vec(fail_vec)
    );

    always #5 clk = ~clk;

    // gate under control: kinds 0..7 follow the op encoding, 8 stuck-at-0, 9 stuck-at-1
    always_comb begin
        gate_y = 1'b0;
        case (kind)
            4'd0: gate_y = gate_a & gate_b;
            4'd1: gate_y = gate_a | gate_b;
            4'd2: gate_y = gate_a ^ gate_b;
            4'd3: gate_y = ~(gate_a & gate_b);
            4'd4: gate_y = ~(gate_a | gate_b);
            4'd5: gate_y = ~(gate_a ^ gate_b);
            4'd6: gate_y = gate_a;
            4'd7: gate_y = ~gate_a;
            4'd9: gate_y = 1'b1;
            default: gate_y = 1'b0;
        endcase
    end

    typedef struct {
        logic [2:0] err;
        logic [3:0] fail;
        logic       pass;
        int         acc;
        int         lat;
    } exp_t;

    typedef struct {
        logic [2:0]    op;
        logic [HW-1:0] hold;
        logic [3:0]    kind;
        logic [2:0]    err;
        logic [3:0]    fail;
        logic          pass;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        #1;
        if (done === 1'b1) begin
            chk("done_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("latency", cyc - mon_e.acc, mon_e.lat);
                chk("err_cnt", err_cnt, mon_e.err);
                chk("fail_vec", fail_vec, mon_e.fail);
                chk("pass", pass, mon_e.pass);
                chk("busy_at_done", busy, 0);
                chk("gate_ab_at_done", {gate_a, gate_b}, 0);
            end
        end
    end

    task automatic run(input logic [2:0] o, input logic [HW-1:0] h, input logic [3:0] k,
                       input logic [2:0] e_err, input logic [3:0] e_fail, input logic e_pass,
                       input bit disturb);
        @(negedge clk);
        op = o; hold = h; kind = k; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        sb.push_back('{e_err, e_fail, e_pass, cyc, 4 * (int'(h) + 2)});
        chk("busy_on_accept", busy, 1);
        for (int v = 0; v < 4; v++) begin
            for (int c = 0; c < int'(h) + 2; c++) begin
                start = disturb && v == 1 && c == 0;
                if (start) begin
                    op = ~o;
                    hold = ~h;
                end
                chk("gate_ab", {gate_a, gate_b}, v);
                chk("busy_in_run", busy, 1);
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        chk("done_pulse", done, 1);
        #1;
        chk("done_consumed", sb.size(), 0);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("idle_err_hold", err_cnt, e_err);
        chk("idle_fail_hold", fail_vec, e_fail);
        chk("idle_pass_hold", pass, e_pass);
    endtask

    vec_t tbl[10];
    int   acc;

    initial begin
        tbl[0] = '{3'd0, 4'd0,  4'd0, 3'd0, 4'b0000, 1'b1};
        tbl[1] = '{3'd1, 4'd2,  4'd0, 3'd2, 4'b0110, 1'b0};
        tbl[2] = '{3'd3, 4'd0,  4'd9, 3'd1, 4'b1000, 1'b0};
        tbl[3] = '{3'd2, 4'd1,  4'd2, 3'd0, 4'b0000, 1'b1};
        tbl[4] = '{3'd4, 4'd0,  4'd0, 3'd2, 4'b1001, 1'b0};
        tbl[5] = '{3'd5, 4'd0,  4'd2, 3'd4, 4'b1111, 1'b0};
        tbl[6] = '{3'd6, 4'd1,  4'd7, 3'd4, 4'b1111, 1'b0};
        tbl[7] = '{3'd7, 4'd0,  4'd4, 3'd1, 4'b0010, 1'b0};
        tbl[8] = '{3'd6, 4'd0,  4'd8, 3'd2, 4'b1100, 1'b0};
        tbl[9] = '{3'd0, 4'd15, 4'd0, 3'd0, 4'b0000, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs", {gate_a, gate_b, busy, done, pass, err_cnt, fail_vec}, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++)
            run(tbl[i].op, tbl[i].hold, tbl[i].kind, tbl[i].err, tbl[i].fail, tbl[i].pass, 1'b0);

        // start/op/hold disturbed mid-run: result must follow the original AND request
        run(3'd0, 4'd1, 4'd0, 3'd0, 4'b0000, 1'b1, 1'b1);
        repeat (20) @(posedge clk);

        // reset in the middle of vector 2 aborts without a done pulse
        @(negedge clk);
        op = 3'd1; hold = '0; kind = 4'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_vec", {gate_a, gate_b}, 2);
        chk("pre_rst_err", err_cnt, 1);
        chk("pre_rst_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_outputs", {gate_a, gate_b, busy, done, pass, err_cnt, fail_vec}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        run(3'd0, 4'd0, 4'd0, 3'd0, 4'b0000, 1'b1, 1'b0);

        // start held high: second run accepted after exactly one idle cycle
        @(negedge clk);
        op = 3'd0; hold = '0; kind = 4'd0; start = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
        sb.push_back('{3'd0, 4'b0000, 1'b1, acc, 8});
        sb.push_back('{3'd0, 4'b0000, 1'b1, acc + 10, 8});
        repeat (9) @(posedge clk);
        #1;
        chk("idle_gap_busy", busy, 0);
        @(posedge clk); #1;
        chk("restart_busy", busy, 1);
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        chk("b2b_done_count", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
